// File: rtl/crc16_tx_sequencer_if.sv
// Handshake and status bundle of the CRC16 TX sequencer (payload in, serial bits out).
// The abort input exists only when CRC16_SEQ_ABORT_EN is defined.
interface crc16_tx_sequencer_if;
    logic        start;
    logic        zlp;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] crc_value;
`ifdef CRC16_SEQ_ABORT_EN
    logic        abort;

    modport master (
        output start, zlp, in_data, in_valid, in_last, bit_ready, abort,
        input  in_ready, bit_out, bit_valid, busy, done, err, crc_value
    );
    modport slave (
        input  start, zlp, in_data, in_valid, in_last, bit_ready, abort,
        output in_ready, bit_out, bit_valid, busy, done, err, crc_value
    );
`else
    modport master (
        output start, zlp, in_data, in_valid, in_last, bit_ready,
        input  in_ready, bit_out, bit_valid, busy, done, err, crc_value
    );
    modport slave (
        input  start, zlp, in_data, in_valid, in_last, bit_ready,
        output in_ready, bit_out, bit_valid, busy, done, err, crc_value
    );
`endif
endinterface

// File: rtl/crc16_tx_sequencer.sv
// Serialises a USB DATA payload LSB-first through a reflected CRC16 (0xA001) and appends ~CRC.
// Optional abort input is compiled in with `define CRC16_SEQ_ABORT_EN.
module crc16_tx_sequencer #(
    parameter int unsigned MAX_BYTES = 1023,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input logic                 clk,
    input logic                 rst,
    crc16_tx_sequencer_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(MAX_BYTES + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam logic [15:0]      POLY    = 16'hA001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CRC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sh_q, sh_d;
    logic [15:0]      crc_q, crc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_s;
    logic             accept_s;
    logic             abort_s;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        crc_step = (crc >> 1) ^ (((crc[0] ^ din) == 1'b1) ? POLY : 16'h0000);
    endfunction

`ifdef CRC16_SEQ_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Byte acceptance: always in LOAD, or on the final-bit transfer of a non-last byte for gap-free streaming.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_q == S_LOAD) begin
            in_ready_s = !abort_s;
        end else if (state_q == S_SHIFT) begin
            in_ready_s = (cnt_q == 4'd7) && bus.bit_ready && !last_q && !abort_s;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.in_valid && in_ready_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    crc_d      = CRC_INIT;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    cnt_d      = 4'd0;
                    state_d    = bus.zlp ? S_CRC : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_LOAD;
            end
            S_SHIFT: begin
                if (bus.bit_ready) begin
                    crc_d = crc_step(crc_q, sh_q[0]);
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        state_d = last_q ? S_CRC : S_LOAD;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_CRC: begin
                if (bus.bit_ready) begin
                    crc_d   = crc_q >> 1;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? S_DONE : S_CRC;
                end else begin
                    state_d = S_CRC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte taken on the final-bit transfer overrides the LOAD/CRC decision made above.
        if (accept_s) begin
            sh_d    = bus.in_data;
            last_d  = bus.in_last;
            cnt_d   = 4'd0;
            state_d = S_SHIFT;
            if (byte_cnt_q == MAX_CNT) begin
                err_d = 1'b1;
            end else begin
                err_d = err_d;
            end
            if (byte_cnt_q <= MAX_CNT) begin
                byte_cnt_d = byte_cnt_q + ONE_CNT;
            end else begin
                byte_cnt_d = byte_cnt_q;
            end
        end else begin
            last_d = last_d;
        end

        if (abort_s && ((state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CRC))) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else begin
            err_d = err_d;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_SHIFT: begin
                bit_out_d   = sh_d[0];
                bit_valid_d = 1'b1;
            end
            S_CRC: begin
                bit_out_d   = ~crc_d[0];
                bit_valid_d = 1'b1;
            end
            default: begin
                bit_out_d   = 1'b0;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sh_q        <= 8'h00;
            crc_q       <= CRC_INIT;
            cnt_q       <= 4'd0;
            byte_cnt_q  <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            last_q      <= last_d;
            err_q       <= err_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.crc_value = crc_q;
endmodule

// File: tb/tb_crc16_tx_sequencer.sv
// Directed bench for crc16_tx_sequencer: reset, ZLP, single byte, back-to-back, stalls, mid-packet reset, overflow.
module tb_crc16_tx_sequencer;
    typedef logic [7:0] bytes_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       zlp = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       bit_ready = 1'b1;

    crc16_tx_sequencer_if bus_if();
    crc16_tx_sequencer_if bus_s_if();

    assign bus_if.start     = start;
    assign bus_if.zlp       = zlp;
    assign bus_if.in_data   = in_data;
    assign bus_if.in_valid  = in_valid;
    assign bus_if.in_last   = in_last;
    assign bus_if.bit_ready = bit_ready;
    assign bus_s_if.start     = start;
    assign bus_s_if.zlp       = zlp;
    assign bus_s_if.in_data   = in_data;
    assign bus_s_if.in_valid  = in_valid;
    assign bus_s_if.in_last   = in_last;
    assign bus_s_if.bit_ready = bit_ready;
`ifdef CRC16_SEQ_ABORT_EN
    assign bus_if.abort   = 1'b0;
    assign bus_s_if.abort = 1'b0;
`endif

    crc16_tx_sequencer dut (.clk(clk), .rst(rst), .bus(bus_if));
    crc16_tx_sequencer #(.MAX_BYTES(2)) dut_s (.clk(clk), .rst(rst), .bus(bus_s_if));

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 1'b0;
    logic        bits_q[$];
    logic        exp_q[$];
    int          done_cnt = 0;
    int          run = 0;
    int          max_run = 0;
    int          acc_cnt = 0;
    int          snap_at = -1;
    logic [15:0] crc_snap = 16'h0000;
    logic        err_s_early = 1'b0;
    bit          acc_seen = 1'b0;
    bytes_t      feed_q;

    // Observe transfers on the opposite edge: a valid&&ready here is taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.bit_valid && (bits_q.size() == snap_at)) crc_snap = bus_if.crc_value;
            if (bus_if.bit_valid && bus_if.bit_ready) bits_q.push_back(bus_if.bit_out);
            if (bus_s_if.busy && (acc_cnt < 3) && bus_s_if.err) err_s_early = 1'b1;
            if (bus_if.in_valid && bus_if.in_ready) begin
                acc_seen = 1'b1;
                acc_cnt++;
            end
            if (bus_if.done) done_cnt++;
            if (bus_if.bit_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bit_ready = ($urandom_range(99, 0) >= 30);
    end

    // Byte feeder: presents feed_q head, pops it once accepted.
    always @(posedge clk) begin
        #1;
        if (acc_seen && (feed_q.size() > 0)) void'(feed_q.pop_front());
        acc_seen = 1'b0;
        if (feed_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = feed_q[0];
            in_last  = (feed_q.size() == 1);
        end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack_bits(input logic q[$]);
        logic [63:0] v;
        v = 64'h0;
        foreach (q[i]) if (i < 64) v[i] = q[i];
        return v;
    endfunction

    function automatic void build_expected(input bytes_t pkt);
        logic [15:0] crc;
        logic        b;
        logic [7:0]  by;
        exp_q.delete();
        crc = 16'hFFFF;
        foreach (pkt[i]) begin
            by = pkt[i];
            for (int k = 0; k < 8; k++) begin
                b = by[k];
                exp_q.push_back(b);
                crc = (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? 16'hA001 : 16'h0000);
            end
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(~crc[k]);
    endfunction

    task automatic run_packet(input bytes_t pkt, input logic is_zlp);
        int c;
        bits_q.delete();
        done_cnt = 0; max_run = 0; run = 0; acc_cnt = 0; err_s_early = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; zlp = is_zlp; feed_q = pkt;
        @(posedge clk); #1;
        start = 1'b0; zlp = 1'b0;
        c = 0;
        while ((done_cnt == 0) && (c < 2000)) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: done_cnt=%0d after %0d cycles, want >0", done_cnt, c);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus_if.in_ready); end
        checks++; if (bus_if.bit_out !== 1'b0) begin errors++; $display("FAIL rst_bit_out: got %b want 0", bus_if.bit_out); end
        checks++; if (bus_if.bit_valid !== 1'b0) begin errors++; $display("FAIL rst_bit_valid: got %b want 0", bus_if.bit_valid); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus_if.done); end
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_if.err); end
        checks++; if (bus_if.crc_value !== 16'hFFFF) begin errors++; $display("FAIL rst_crc: got %h want ffff", bus_if.crc_value); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zlp();
        bytes_t none;
        none = {};
        run_packet(none, 1'b1);
        checks++; if (bits_q.size() !== 16) begin errors++; $display("FAIL zlp_len: got %0d want 16", bits_q.size()); end
        checks++; if (pack_bits(bits_q) !== 64'h0) begin errors++; $display("FAIL zlp_bits: got %h want 0", pack_bits(bits_q)); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zlp_done: got %0d pulses want 1", done_cnt); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL zlp_busy: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_single_byte();
        bytes_t pkt;
        pkt = {8'h00};
        snap_at = 8;
        run_packet(pkt, 1'b0);
        snap_at = -1;
        checks++; if (bits_q.size() !== 24) begin errors++; $display("FAIL one_len: got %0d want 24", bits_q.size()); end
        checks++; if (pack_bits(bits_q) !== 64'h0000_0000_00BF_4000) begin errors++; $display("FAIL one_bits: got %h want bf4000", pack_bits(bits_q)); end
        checks++; if (crc_snap !== 16'h40BF) begin errors++; $display("FAIL one_crc: got %h want 40bf", crc_snap); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL one_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bytes_t pkt;
        pkt = {8'h00, 8'h01, 8'h02, 8'h03};
        build_expected(pkt);
        run_packet(pkt, 1'b0);
        checks++; if (bits_q.size() !== 48) begin errors++; $display("FAIL b2b_len: got %0d want 48", bits_q.size()); end
        checks++; if (pack_bits(bits_q) !== pack_bits(exp_q)) begin errors++; $display("FAIL b2b_bits: got %h want %h", pack_bits(bits_q), pack_bits(exp_q)); end
        checks++; if (max_run !== 48) begin errors++; $display("FAIL b2b_gapless: got run %0d want 48", max_run); end
    endtask

    task automatic test_stall();
        bytes_t      pkt;
        logic [63:0] ref_v;
        pkt = {8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        build_expected(pkt);
        run_packet(pkt, 1'b0);
        ref_v = pack_bits(bits_q);
        rand_ready = 1'b1;
        run_packet(pkt, 1'b0);
        rand_ready = 1'b0;
        @(posedge clk); #2;
        bit_ready = 1'b1;
        checks++; if (bits_q.size() !== 56) begin errors++; $display("FAIL stall_len: got %0d want 56", bits_q.size()); end
        checks++; if (pack_bits(bits_q) !== ref_v) begin errors++; $display("FAIL stall_vs_nostall: got %h want %h", pack_bits(bits_q), ref_v); end
        checks++; if (pack_bits(bits_q) !== pack_bits(exp_q)) begin errors++; $display("FAIL stall_model: got %h want %h", pack_bits(bits_q), pack_bits(exp_q)); end
    endtask

    task automatic test_reset_mid();
        bytes_t pkt;
        bytes_t none;
        int     c;
        pkt = {8'hF0, 8'h0F};
        none = {};
        bits_q.delete();
        @(posedge clk); #1;
        start = 1'b1; feed_q = pkt;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while ((bits_q.size() < 11) && (c < 200)) begin
            @(negedge clk);
            c++;
        end
        checks++; if (bits_q.size() < 11) begin errors++; $display("FAIL midrst_reach: got %0d bits want >=11", bits_q.size()); end
        @(posedge clk); #1;
        rst = 1'b1; feed_q.delete(); acc_seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.bit_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus_if.bit_valid); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus_if.busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_packet(none, 1'b1);
        checks++; if ((bits_q.size() !== 16) || (pack_bits(bits_q) !== 64'h0)) begin
            errors++; $display("FAIL midrst_zlp: got %0d bits %h want 16 bits 0", bits_q.size(), pack_bits(bits_q));
        end
    endtask

    task automatic test_overflow();
        bytes_t pkt;
        bytes_t none;
        pkt = {8'h11, 8'h22, 8'h33};
        none = {};
        build_expected(pkt);
        run_packet(pkt, 1'b0);
        checks++; if (err_s_early !== 1'b0) begin errors++; $display("FAIL ovf_early: err seen before 3rd accept, got %b want 0", err_s_early); end
        checks++; if (bus_s_if.err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", bus_s_if.err); end
        checks++; if (bus_if.err !== 1'b0) begin errors++; $display("FAIL ovf_default_err: got %b want 0", bus_if.err); end
        checks++; if ((bits_q.size() !== 40) || (pack_bits(bits_q) !== pack_bits(exp_q))) begin
            errors++; $display("FAIL ovf_bits: got %0d bits %h want 40 bits %h", bits_q.size(), pack_bits(bits_q), pack_bits(exp_q));
        end
        run_packet(none, 1'b1);
        checks++; if (bus_s_if.err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus_s_if.err); end
    endtask

    initial begin
        test_reset();
        test_zlp();
        test_single_byte();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
